ff_vga_linedbl: RTL and testbench

Line-doubling scan converter between the Food Fight arcade video generator and the board VGA pins. It captures each arcade scanline into a ping-pong line buffer at the arcade pixel rate. It replays the previous line twice at the VGA pixel rate with locally generated horizontal sync and blank. Its outputs drive `vga_hsync`, `vga_vsync`, `vga_blank` and the RGB pins of the LX45 top, which the VGA capture bench samples.

---
 rtl/ff_vga_linedbl.sv | 140 ++++++++++++++
 tb/tb_ff_vga_linedbl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ff_vga_linedbl.sv
// Line-doubling scan converter: captures arcade lines into a ping-pong buffer and
// replays the previous line twice at the VGA pixel rate with local hsync/blank.
module ff_vga_linedbl #(
  parameter int unsigned ARC_W        = 256,
  parameter int unsigned RGB_W        = 8,
  parameter int unsigned H_TOTAL      = 400,
  parameter int unsigned H_SYNC_START = 300,
  parameter int unsigned H_SYNC_END   = 348
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arc_pix_ce,
  input  logic             arc_hsync,
  input  logic             arc_vsync,
  input  logic [RGB_W-1:0] arc_rgb,
  input  logic             vga_pix_ce,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_blank,
  output logic [RGB_W-1:0] vga_rgb
);

  localparam int unsigned AW = $clog2(ARC_W);
  localparam int unsigned XW = $clog2(ARC_W + 1);
  localparam int unsigned HW = $clog2(H_TOTAL);

  logic [RGB_W-1:0] mem [2][ARC_W];

  logic          arc_hsync_q;
  logic          line_start_c;
  logic          wr_bank;
  logic [XW-1:0] wr_x;
  logic          wr_en_c;
  logic          wr_sel_c;
  logic [AW-1:0] wr_addr_c;
  logic [HW-1:0] hcount;
  logic [1:0]    rep;
  logic          vs_line;
  logic          seen_start;
  logic          valid;
  logic          act_c;
  logic          hs_c;
  logic          act_q;
  logic          hs_q;
  logic [AW-1:0] rd_addr;
  logic [RGB_W-1:0] rd_data_c;

  assign line_start_c = arc_hsync & ~arc_hsync_q;

  // A pixel arriving on the line-start cycle lands at x=0 of the newly selected bank.
  always_comb begin
    wr_sel_c  = wr_bank;
    wr_addr_c = wr_x[AW-1:0];
    wr_en_c   = 1'b0;
    if (line_start_c) begin
      wr_sel_c  = ~wr_bank;
      wr_addr_c = '0;
      wr_en_c   = arc_pix_ce & ~reset;
    end else begin
      wr_en_c   = arc_pix_ce & ~reset & (wr_x < XW'(ARC_W));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_sel_c][wr_addr_c] <= arc_rgb;
  end

  // Write pointer and bank select; wr_x saturates at ARC_W to drop overrun pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      arc_hsync_q <= 1'b0;
      wr_bank     <= 1'b0;
      wr_x        <= '0;
      vs_line     <= 1'b0;
      seen_start  <= 1'b0;
      valid       <= 1'b0;
    end else begin
      arc_hsync_q <= arc_hsync;
      if (line_start_c) begin
        wr_bank    <= ~wr_bank;
        wr_x       <= arc_pix_ce ? XW'(1) : '0;
        vs_line    <= arc_vsync;
        seen_start <= 1'b1;
        if (seen_start) valid <= 1'b1;
      end else if (arc_pix_ce && (wr_x < XW'(ARC_W))) begin
        wr_x <= wr_x + XW'(1);
      end
    end
  end

  // VGA horizontal counter; a line start overrides any same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      rep    <= '0;
    end else if (line_start_c) begin
      hcount <= '0;
      rep    <= '0;
    end else if (vga_pix_ce) begin
      if (hcount == HW'(H_TOTAL - 1)) begin
        hcount <= '0;
        if (rep != 2'd3) rep <= rep + 2'd1;
      end else begin
        hcount <= hcount + HW'(1);
      end
    end
  end

  assign act_c     = valid & (hcount < HW'(ARC_W));
  assign hs_c      = (hcount >= HW'(H_SYNC_START)) & (hcount < HW'(H_SYNC_END));
  assign rd_data_c = mem[~wr_bank][rd_addr];

  // Read address and per-pixel terms are registered together so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr <= '0;
      act_q   <= 1'b0;
      hs_q    <= 1'b0;
    end else begin
      rd_addr <= hcount[AW-1:0];
      act_q   <= act_c;
      hs_q    <= hs_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_blank <= 1'b1;
      vga_rgb   <= '0;
    end else if (vga_pix_ce) begin
      vga_rgb   <= act_q ? rd_data_c : '0;
      vga_blank <= ~act_q;
      vga_hsync <= ~hs_q;
      vga_vsync <= ~vs_line;
    end
  end

endmodule

// File: tb/tb_ff_vga_linedbl.sv
// Randomized bench for ff_vga_linedbl against a line-buffer reference model.
module tb_ff_vga_linedbl;

  localparam int unsigned ARC_W = 256;
  localparam int unsigned RGB_W = 8;
  localparam int unsigned H_TOT = 400;

  logic             clk = 1'b0;
  logic             reset;
  logic             arc_pix_ce;
  logic             arc_hsync;
  logic             arc_vsync;
  logic [RGB_W-1:0] arc_rgb;
  logic             vga_pix_ce;
  logic             vga_hsync;
  logic             vga_vsync;
  logic             vga_blank;
  logic [RGB_W-1:0] vga_rgb;

  always #5 clk = ~clk;

  ff_vga_linedbl #(
    .ARC_W(ARC_W), .RGB_W(RGB_W), .H_TOTAL(H_TOT),
    .H_SYNC_START(300), .H_SYNC_END(348)
  ) dut (
    .clk(clk), .reset(reset),
    .arc_pix_ce(arc_pix_ce), .arc_hsync(arc_hsync), .arc_vsync(arc_vsync), .arc_rgb(arc_rgb),
    .vga_pix_ce(vga_pix_ce),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank), .vga_rgb(vga_rgb)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int vs_low_ticks = 0;

  // Reference: two line buffers with per-entry "known" flags (RAM is not reset).
  logic [RGB_W-1:0] mb [2][ARC_W];
  bit               mk [2][ARC_W];
  int  m_h, m_wx, m_starts;
  bit  m_wb, m_vs, m_prev_hs;
  bit  e_hs = 1'b1, e_vs = 1'b1, e_blank = 1'b1, e_known = 1'b1;
  logic [RGB_W-1:0] e_rgb = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick(input bit rst, input bit pce, input bit hs, input bit vs,
                      input logic [RGB_W-1:0] rgb);
    bit vce, ls, act;
    vce = (cyc % 2 == 0);
    reset = rst; arc_pix_ce = pce; arc_hsync = hs; arc_vsync = vs; arc_rgb = rgb;
    vga_pix_ce = vce;
    ls = !rst && hs && !m_prev_hs;
    if (rst) begin
      e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b1; e_rgb = '0; e_known = 1'b1;
    end else if (vce) begin
      // Output after this tick shows the pixel at the model's current horizontal position.
      act     = (m_starts >= 2) && (m_h < int'(ARC_W));
      e_blank = !act;
      e_hs    = !(m_h >= 300 && m_h < 348);
      e_vs    = !m_vs;
      if (act) begin
        e_rgb   = mb[!m_wb][m_h];
        e_known = mk[!m_wb][m_h];
      end else begin
        e_rgb   = '0;
        e_known = 1'b1;
      end
    end
    @(posedge clk);
    if (rst) begin
      m_h = 0; m_wb = 1'b0; m_wx = 0; m_starts = 0; m_vs = 1'b0; m_prev_hs = 1'b0;
    end else begin
      m_prev_hs = hs;
      if (ls) begin
        m_starts++;
        m_vs = vs; m_h = 0; m_wb = !m_wb; m_wx = 0;
      end else if (vce) begin
        m_h = (m_h == int'(H_TOT) - 1) ? 0 : m_h + 1;
      end
      if (pce && m_wx < int'(ARC_W)) begin
        mb[m_wb][m_wx] = rgb;
        mk[m_wb][m_wx] = 1'b1;
        m_wx++;
      end
    end
    @(negedge clk);
    check("hsync", 32'(vga_hsync), 32'(e_hs));
    check("vsync", 32'(vga_vsync), 32'(e_vs));
    check("blank", 32'(vga_blank), 32'(e_blank));
    if (e_known) check("rgb", 32'(vga_rgb), 32'(e_rgb));
    if (vce && !rst && !vga_vsync) vs_low_ticks++;
    cyc++;
  endtask

  // One arcade line: hsync pulse at its start, a pixel strobe every 4th clk.
  task automatic run_line(input int len, input bit vs, input bit ramp, input int rst_at);
    int px;
    bit pce;
    logic [RGB_W-1:0] d;
    px = 0;
    for (int c = 0; c < len; c++) begin
      pce = (c % 4 == 2);
      d   = ramp ? RGB_W'(px) : RGB_W'($urandom);
      tick((c >= rst_at) && (c < rst_at + 3), pce, c < 16, vs, d);
      if (pce) px++;
    end
  endtask

  initial begin
    m_h = 0; m_wx = 0; m_starts = 0; m_wb = 1'b0; m_vs = 1'b0; m_prev_hs = 1'b0;
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), RGB_W'($urandom));
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0);

    for (int l = 0; l < 4; l++) run_line(1600, 1'b0, 1'b1, -10);
    for (int l = 0; l < 3; l++) run_line(1600, 1'b1, 1'b0, -10);
    for (int l = 0; l < 2; l++) run_line(1600, 1'b0, 1'b0, -10);
    run_line(1040, 1'b0, 1'b0, -10);
    run_line(600,  1'b0, 1'b0, -10);
    for (int l = 0; l < 2; l++) run_line(1600, 1'b0, 1'b0, -10);
    run_line(1600, 1'b0, 1'b1, 501);
    for (int l = 0; l < 3; l++) run_line(1600, 1'b0, 1'b0, -10);
    for (int l = 0; l < 4; l++) run_line(2 * int'($urandom_range(300, 900)), 1'b0, 1'b0, -10);
    run_line(1600, 1'b0, 1'b0, -10);

    check("vs_low_ticks", 32'(vs_low_ticks), 32'(2400));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
